// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: framed command decoder sitting behind the 8N1 UART receiver.
// Accepts 7-byte frames (SYNC, ADDR, D0..D3, CHK), validates the address and
// XOR checksum, and issues a one-cycle registered config write. Keeps the
// shadow tuning word (reg 0), pulses an error on rejected or timed-out frames,
// and keeps a saturating count of those rejections.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CLKS = 23100,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter logic [31:0] FREQ_RESET   = 32'h0
) (
    input  logic        osc_clk,
    input  logic        rst_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_cfg_wr,
    output logic [1:0]  o_cfg_addr,
    output logic [31:0] o_cfg_data,
    output logic [31:0] o_freq_word,
    output logic        o_frame_err,
    output logic [7:0]  o_err_cnt,
    output logic        o_busy
);

    localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_HUNT,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    xor_q, xor_d;
    logic [31:0]   asm_q, asm_d;
    logic [1:0]    faddr_q, faddr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          wr_q, wr_d;
    logic [1:0]    cfg_addr_q, cfg_addr_d;
    logic [31:0]   cfg_data_q, cfg_data_d;
    logic [31:0]   freq_q, freq_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          bad_frame;

    // Next-state and output decode; only a byte strobe or the inter-byte timer advances the frame.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        xor_d      = xor_q;
        asm_d      = asm_q;
        faddr_d    = faddr_q;
        timer_d    = timer_q;
        wr_d       = 1'b0;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        freq_d     = freq_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        bad_frame  = 1'b0;

        if (i_Rx_DV) begin
            // A strobe on the terminal timer count still wins: the byte is consumed normally.
            timer_d = '0;
            unique case (state_q)
                S_HUNT: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (i_Rx_Byte[7:2] != 6'd0) begin
                        bad_frame = 1'b1;
                        state_d   = S_HUNT;
                    end else begin
                        faddr_d = i_Rx_Byte[1:0];
                        xor_d   = i_Rx_Byte;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    asm_d[{idx_q, 3'b000} +: 8] = i_Rx_Byte;
                    xor_d = xor_q ^ i_Rx_Byte;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    if (i_Rx_Byte == xor_q) begin
                        wr_d       = 1'b1;
                        cfg_addr_d = faddr_q;
                        cfg_data_d = asm_q;
                        if (faddr_q == 2'd0) begin
                            freq_d = asm_q;
                        end
                    end else begin
                        bad_frame = 1'b1;
                    end
                    state_d = S_HUNT;
                end
                default: state_d = S_HUNT;
            endcase
        end else if (state_q != S_HUNT) begin
            if (timer_q == TMO_LAST) begin
                bad_frame = 1'b1;
                state_d   = S_HUNT;
                timer_d   = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        if (bad_frame) begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HUNT;
            idx_q      <= '0;
            xor_q      <= '0;
            asm_q      <= '0;
            faddr_q    <= '0;
            timer_q    <= '0;
            wr_q       <= 1'b0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
            freq_q     <= FREQ_RESET;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            xor_q      <= xor_d;
            asm_q      <= asm_d;
            faddr_q    <= faddr_d;
            timer_q    <= timer_d;
            wr_q       <= wr_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            freq_q     <= freq_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_cfg_wr    = wr_q;
    assign o_cfg_addr  = cfg_addr_q;
    assign o_cfg_data  = cfg_data_q;
    assign o_freq_word = freq_q;
    assign o_frame_err = err_q;
    assign o_err_cnt   = cnt_q;
    assign o_busy      = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and randomized byte streams against a
// frame-buffer reference model; all outputs compared every cycle.
module tb_uart_cmd_ctrl;

    localparam int unsigned TMO  = 40;
    localparam logic [31:0] FRST = 32'hDEAD_BEEF;

    logic        osc_clk = 1'b0;
    logic        rst_n;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        o_cfg_wr;
    logic [1:0]  o_cfg_addr;
    logic [31:0] o_cfg_data;
    logic [31:0] o_freq_word;
    logic        o_frame_err;
    logic [7:0]  o_err_cnt;
    logic        o_busy;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    logic [7:0]  mbuf[$];
    int          m_idle;
    logic        m_wr, m_err;
    logic [1:0]  m_addr;
    logic [31:0] m_data, m_freq;
    logic [7:0]  m_cnt;

    uart_cmd_ctrl #(
        .TIMEOUT_CLKS(TMO),
        .SYNC_BYTE   (8'hA5),
        .FREQ_RESET  (FRST)
    ) dut (
        .osc_clk    (osc_clk),
        .rst_n      (rst_n),
        .i_Rx_DV    (i_Rx_DV),
        .i_Rx_Byte  (i_Rx_Byte),
        .o_cfg_wr   (o_cfg_wr),
        .o_cfg_addr (o_cfg_addr),
        .o_cfg_data (o_cfg_data),
        .o_freq_word(o_freq_word),
        .o_frame_err(o_frame_err),
        .o_err_cnt  (o_err_cnt),
        .o_busy     (o_busy)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mbuf.delete();
        m_idle = 0;
        m_wr   = 1'b0;
        m_err  = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_freq = FRST;
        m_cnt  = '0;
    endtask

    // Frame-level model: collect bytes of the current frame, judge at 2 and 7 bytes.
    task automatic model_step(input logic dv, input logic [7:0] b);
        logic [7:0] a, x;
        m_wr  = 1'b0;
        m_err = 1'b0;
        if (dv) begin
            m_idle = 0;
            if (mbuf.size() == 0) begin
                if (b == 8'hA5) mbuf.push_back(b);
            end else begin
                mbuf.push_back(b);
                if (mbuf.size() == 2 && b[7:2] != 6'd0) begin
                    m_err = 1'b1;
                    mbuf.delete();
                end else if (mbuf.size() == 7) begin
                    x = mbuf[1] ^ mbuf[2] ^ mbuf[3] ^ mbuf[4] ^ mbuf[5];
                    if (mbuf[6] == x) begin
                        a      = mbuf[1];
                        m_wr   = 1'b1;
                        m_addr = a[1:0];
                        m_data = {mbuf[5], mbuf[4], mbuf[3], mbuf[2]};
                        if (m_addr == 2'd0) m_freq = m_data;
                    end else begin
                        m_err = 1'b1;
                    end
                    mbuf.delete();
                end
            end
        end else if (mbuf.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err  = 1'b1;
                m_idle = 0;
                mbuf.delete();
            end
        end
        if (m_err && m_cnt != 8'hFF) m_cnt++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wr"},   {31'd0, o_cfg_wr},    {31'd0, m_wr});
        check({tag, ".err"},  {31'd0, o_frame_err}, {31'd0, m_err});
        check({tag, ".busy"}, {31'd0, o_busy},      {31'd0, (mbuf.size() != 0)});
        check({tag, ".cnt"},  {24'd0, o_err_cnt},   {24'd0, m_cnt});
        check({tag, ".addr"}, {30'd0, o_cfg_addr},  {30'd0, m_addr});
        check({tag, ".data"}, o_cfg_data,           m_data);
        check({tag, ".freq"}, o_freq_word,          m_freq);
    endtask

    task automatic tick(input string tag, input logic dv, input logic [7:0] b);
        i_Rx_DV   = dv;
        i_Rx_Byte = b;
        @(posedge osc_clk);
        model_step(dv, b);
        #1;
        check_all(tag);
    endtask

    // gap idle cycles (junk on the byte bus), then one strobed byte
    task automatic send_byte(input string tag, input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) tick(tag, 1'b0, 8'($urandom));
        tick(tag, 1'b1, b);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] ad, input logic [31:0] d,
                              input logic corrupt, input int gap);
        logic [7:0] c;
        c = ad ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
        if (corrupt) c = c ^ 8'(1 << $urandom_range(0, 7));
        send_byte(tag, 8'hA5, gap);
        send_byte(tag, ad, gap);
        send_byte(tag, d[7:0], gap);
        send_byte(tag, d[15:8], gap);
        send_byte(tag, d[23:16], gap);
        send_byte(tag, d[31:24], gap);
        send_byte(tag, c, gap);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, 8'($urandom));
    endtask

    initial begin
        int          r, g;
        logic [7:0]  ad;
        logic [31:0] d;

        rst_n     = 1'b0;
        i_Rx_DV   = 1'b0;
        i_Rx_Byte = 8'h00;
        model_reset();
        repeat (2) @(posedge osc_clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // directed vectors
        send_frame("f_reg0", 8'h00, 32'h1234_5678, 1'b0, 0);
        idle("f_reg0", 2);
        send_frame("f_reg2", 8'h02, 32'h0000_0001, 1'b0, 1);
        idle("f_reg2", 2);
        send_byte("badchk", 8'hA5, 0);
        send_byte("badchk", 8'h00, 0);
        send_byte("badchk", 8'h78, 0);
        send_byte("badchk", 8'h56, 0);
        send_byte("badchk", 8'h34, 0);
        send_byte("badchk", 8'h12, 0);
        send_byte("badchk", 8'h09, 0);
        idle("badchk", 2);
        send_byte("lead", 8'h00, 0);
        send_byte("lead", 8'hFF, 0);
        send_byte("lead", 8'hA5, 0);
        send_byte("lead", 8'h05, 0);
        send_frame("lead_ok", 8'h01, 32'hCAFE_F00D, 1'b0, 0);
        send_frame("sync_addr", 8'hA5, 32'h0, 1'b0, 0);

        // timeout, and the DV-on-terminal-count boundary
        send_byte("tmo", 8'hA5, 0);
        send_byte("tmo", 8'h01, 0);
        send_byte("tmo", 8'hAA, 0);
        idle("tmo", TMO + 3);
        send_frame("edge_ok", 8'h03, 32'h8765_4321, 1'b0, TMO - 1);
        send_frame("edge_tmo", 8'h00, 32'h1111_2222, 1'b0, TMO);
        idle("edge_tmo", 4);

        // reset in the middle of the data bytes
        send_byte("rst_mid", 8'hA5, 0);
        send_byte("rst_mid", 8'h00, 0);
        send_byte("rst_mid", 8'h44, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        repeat (2) @(posedge osc_clk);
        #1;
        rst_n = 1'b1;
        send_frame("post_rst", 8'h00, 32'h0BAD_CAFE, 1'b0, 0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            r  = $urandom_range(0, 9);
            g  = ($urandom_range(0, 19) == 0) ? (TMO - 1 + $urandom_range(0, 1)) : $urandom_range(0, 3);
            ad = 8'($urandom_range(0, 3));
            d  = $urandom;
            if (r <= 4) begin
                send_frame("rnd_ok", ad, d, 1'b0, g);
            end else if (r <= 6) begin
                send_frame("rnd_chk", ad, d, 1'b1, g);
            end else if (r == 7) begin
                send_frame("rnd_addr", ad | 8'(4 << $urandom_range(0, 5)), d, 1'b0, g);
            end else begin
                send_byte("rnd_junk", 8'($urandom), g);
                send_frame("rnd_junk", ad, d, 1'b0, g);
            end
        end

        // push the error counter through saturation
        for (int n = 0; n < 260; n++) begin
            send_byte("sat", 8'hA5, 0);
            send_byte("sat", 8'h05, 0);
        end
        idle("sat", 2);
        check("sat_final", {24'd0, o_err_cnt}, 32'h0000_00FF);
        send_frame("sat_ok", 8'h02, 32'h5A5A_A5A5, 1'b0, 0);
        idle("end", 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
